frame_tx: RTL and testbench

Bit-serial frame transmitter. Accepts a parallel word on a valid/ready handshake and drives it LSB-first onto a three-wire serial link (`ser_data`, `ser_frame`, `ser_last`). It is the sending end of the link whose receiving module deserializes `ser_*` back into words. It sits between a word-producing block and the serial pins.

---
 rtl/frame_tx_pkg.sv | 23 ++
 rtl/frame_tx_gap_cnt.sv | 31 +++
 rtl/frame_tx.sv | 115 +++++++++++
 tb/tb_frame_tx.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_tx_pkg.sv
// frame_tx_pkg: shared types and helpers for the bit-serial frame link.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a. FRAME_TX_PARITY_EN selects one even-parity bit per frame.
package frame_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } frame_tx_state_e;

`ifdef FRAME_TX_PARITY_EN
   localparam int FRAME_TX_PARITY_BITS = 1;
`else
   localparam int FRAME_TX_PARITY_BITS = 0;
`endif

   // Number of cycles ser_frame is high for one word.
   function automatic int frame_tx_len(input int data_w);
      return data_w + FRAME_TX_PARITY_BITS;
   endfunction

endpackage

// File: rtl/frame_tx_gap_cnt.sv
// frame_tx_gap_cnt: down-counter loaded with GAP_CYCLES, done while it reads 0.
// Latency: load/decrement visible the cycle after the edge; done is a decode of the count.
// Backpressure: none; it holds at 0 once expired.
// Ports: clk, rst_n (sync, active-low), load (reload GAP_CYCLES), en (count down), done.
module frame_tx_gap_cnt #(
   parameter int GAP_CYCLES = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic done
);

   localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

   logic [GW-1:0] count;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= GW'(GAP_CYCLES);
      end else if (en && (count != '0)) begin
         count <= count - GW'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/frame_tx.sv
// frame_tx: serializes one DATA_W word per handshake onto ser_data/ser_frame/ser_last, LSB first.
// Latency: handshake at edge N puts bit 0 on ser_data in the cycle after edge N; all outputs registered.
// Backpressure: in_ready is high only in IDLE; word period is frame length + GAP_CYCLES + 1.
// Ports: clk, rst_n (sync, active-low), in_data/in_valid/in_ready (word input),
//        ser_data/ser_frame/ser_last (serial link), busy (state != IDLE).
// Build option: define FRAME_TX_PARITY_EN to append an even-parity bit to every frame.
module frame_tx
   import frame_tx_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ser_data,
   output logic              ser_frame,
   output logic              ser_last,
   output logic              busy
);

   localparam int FRAME_W = frame_tx_len(DATA_W);
   localparam int CW      = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_W - 1);

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_SHIFT = SHIFT;
   localparam logic [1:0] ST_GAP   = GAP;

   logic [1:0]         state, state_nxt;
   logic [FRAME_W-1:0] sreg, sreg_nxt, sreg_load;
   logic [CW-1:0]      bitcnt, bitcnt_nxt;
   logic               hs;
   logic               last_bit;
   logic               gap_done;

   // in_ready is itself a flop that is only high in IDLE, so this is the IDLE accept.
   assign hs       = in_valid && in_ready;
   assign last_bit = (state == ST_SHIFT) && (bitcnt == LAST_IDX);

   // The parity bit rides on top of the data in the shift register, so it falls out
   // naturally as the last serial bit.
`ifdef FRAME_TX_PARITY_EN
   assign sreg_load = {^in_data, in_data};
`else
   assign sreg_load = in_data;
`endif

   always_comb begin
      state_nxt  = state;
      sreg_nxt   = sreg;
      bitcnt_nxt = bitcnt;
      case (state)
         ST_IDLE: begin
            if (hs) begin
               state_nxt  = ST_SHIFT;
               sreg_nxt   = sreg_load;
               bitcnt_nxt = '0;
            end
         end
         ST_SHIFT: begin
            sreg_nxt   = sreg >> 1;
            bitcnt_nxt = bitcnt + CW'(1);
            if (last_bit) begin
               state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_done) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The gap count starts on the last-bit cycle so that done is seen in the final
   // gap cycle, giving exactly GAP_CYCLES cycles in GAP.
   frame_tx_gap_cnt #(
      .GAP_CYCLES (GAP_CYCLES)
   ) u_gap_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (hs),
      .en    (last_bit || (state == ST_GAP)),
      .done  (gap_done)
   );

   // Outputs are registered from next-state values so they line up with the state
   // they describe, with no input-to-output combinational path.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         sreg      <= '0;
         bitcnt    <= '0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         ser_data  <= 1'b0;
         ser_frame <= 1'b0;
         ser_last  <= 1'b0;
      end else begin
         state     <= state_nxt;
         sreg      <= sreg_nxt;
         bitcnt    <= bitcnt_nxt;
         in_ready  <= (state_nxt == ST_IDLE);
         busy      <= (state_nxt != ST_IDLE);
         ser_frame <= (state_nxt == ST_SHIFT);
         ser_data  <= (state_nxt == ST_SHIFT) && sreg_nxt[0];
         ser_last  <= (state_nxt == ST_SHIFT) && (bitcnt_nxt == LAST_IDX);
      end
   end

endmodule

// File: tb/tb_frame_tx.sv
// tb_frame_tx: self-checking bench for frame_tx (GAP_CYCLES=1 main instance, GAP_CYCLES=0 second instance).
// Latency: expected frames are queued when a word is offered and compared bit by bit as ser_frame runs.
// Backpressure: in_valid is held until the bench observes the handshake.
module tb_frame_tx;

`ifdef FRAME_TX_PARITY_EN
   localparam int FRAME = 9;
`else
   localparam int FRAME = 8;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready, ser_data, ser_frame, ser_last, busy;

   logic [7:0] b_data;
   logic       b_valid;
   logic       b_ready, b_sdata, b_frame, b_last, b_busy;

   frame_tx #(.DATA_W(8), .GAP_CYCLES(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ser_data  (ser_data),
      .ser_frame (ser_frame),
      .ser_last  (ser_last),
      .busy      (busy)
   );

   frame_tx #(.DATA_W(8), .GAP_CYCLES(0)) dut0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (b_data),
      .in_valid  (b_valid),
      .in_ready  (b_ready),
      .ser_data  (b_sdata),
      .ser_frame (b_frame),
      .ser_last  (b_last),
      .busy      (b_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [8:0] bits;   // bit 8 is the parity bit, only looked at when len is 9
      int         len;
   } frm_t;

   typedef struct {
      logic [7:0] data;
      logic       par;    // expected even-parity bit
   } vec_t;

   frm_t exp_q[$];
   frm_t cur;
   vec_t tbl[6];
   int   idx;
   bit   active;
   bit   prev_rdy;
   bit   hs;
   int   cyc;
   int   last_hs;
   int   checks;
   int   passed;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   function automatic frm_t mk(input logic [7:0] d, input logic par);
      frm_t f;
      f.bits = {par, d};
      f.len  = FRAME;
      return f;
   endfunction

   // Called once per cycle at the falling edge: outputs are stable, and the inputs
   // still hold what the DUT saw at the rising edge just passed.
   task automatic mon();
      cyc++;
      hs = 1'b0;
      if (!rst_n) begin
         chk($sformatf("reset_outputs@%0d", cyc), {in_ready, busy, ser_data, ser_frame, ser_last}, 5'b0);
         exp_q.delete();
         active   = 1'b0;
         prev_rdy = in_ready;
         return;
      end
      hs = prev_rdy && in_valid;
      if (hs) last_hs = cyc;
      if (ser_frame) begin
         if (!active) begin
            chk($sformatf("frame_expected@%0d", cyc), (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               cur    = exp_q.pop_front();
               idx    = 0;
               active = 1'b1;
            end
         end
         if (active) begin
            chk($sformatf("ser_data[%0d]@%0d", idx, cyc), ser_data, cur.bits[idx]);
            chk($sformatf("ser_last[%0d]@%0d", idx, cyc), ser_last, (idx == cur.len - 1));
            idx++;
            if (idx == cur.len) active = 1'b0;
         end
      end else if (active) begin
         chk($sformatf("frame_len@%0d", cyc), idx, cur.len);
         active = 1'b0;
      end
      prev_rdy = in_ready;
   endtask

   task automatic cycle();
      @(negedge clk);
      mon();
   endtask

   task automatic send(input logic [7:0] d, input logic par, input bit keep);
      int n;
      in_data  = d;
      in_valid = 1'b1;
      exp_q.push_back(mk(d, par));
      n = 0;
      do begin
         cycle();
         n++;
      end while (!hs && n < 40);
      chk($sformatf("handshake_%02h", d), hs, 1);
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!in_ready && n < 40);
   endtask

   initial begin
      int         n, h1, h2, nb, k;
      logic [8:0] bbits;
      logic [7:0] d;

      checks = 0; passed = 0; cyc = 0; active = 1'b0; prev_rdy = 1'b0; last_hs = 0;
      tbl = '{'{8'h07, 1'b1}, '{8'h03, 1'b0}, '{8'h80, 1'b1},
              '{8'h5A, 1'b0}, '{8'h00, 1'b0}, '{8'hFE, 1'b1}};

      // Reset held 3 cycles with in_valid high; the monitor checks all-zero outputs.
      rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hA5; b_valid = 1'b0; b_data = 8'h00;
      repeat (3) cycle();
      rst_n = 1'b1;
      cycle();
      chk("ready_after_release", in_ready, 1);
      chk("no_hs_at_release", {hs, busy, ser_frame}, 3'b000);

      // Single word A5: bits checked by the monitor, then one gap cycle before ready.
      send(8'hA5, 1'b0, 1'b0);
      wait_ready(n);
      chk("a5_ready_delay", n, FRAME + 1);
      chk("a5_idle_busy", busy, 0);

      // Back-to-back with in_valid held high.
      send(8'h01, 1'b1, 1'b1);
      h1 = last_hs;
      send(8'hFF, 1'b0, 1'b0);
      h2 = last_hs;
      chk("b2b_period", h2 - h1, FRAME + 2);
      wait_ready(n);

      // Table words; a valid pulse with other data while busy must be ignored.
      for (int i = 0; i < 6; i++) begin
         send(tbl[i].data, tbl[i].par, 1'b0);
         in_data  = 8'hEE;
         in_valid = 1'b1;
         cycle();
         chk($sformatf("valid_ignored_%0d", i), hs, 0);
         in_valid = 1'b0;
         wait_ready(n);
         chk($sformatf("tbl_ready_delay_%0d", i), n, FRAME);
      end

      // A few random words, parity from the even-parity definition.
      for (int i = 0; i < 4; i++) begin
         d = 8'($urandom);
         send(d, ^d, 1'b0);
         wait_ready(n);
         chk($sformatf("rnd_ready_delay_%0d", i), n, FRAME + 1);
      end

      // GAP_CYCLES = 0 instance: ready comes back right after the last-bit cycle.
      chk("g0_idle_ready", b_ready, 1);
      b_data = 8'h80; b_valid = 1'b1;
      cycle();
      b_valid = 1'b0;
      bbits = '0; nb = 0; k = 0;
      while (k < 30) begin
         if (b_frame && nb < 9) begin
            bbits[nb] = b_sdata;
            nb++;
         end
         if (b_last) break;
         cycle();
         k++;
      end
      chk("g0_bits", bbits, (FRAME == 9) ? 9'h180 : 9'h080);
      chk("g0_len", nb, FRAME);
      cycle();
      chk("g0_ready_after_last", {b_ready, b_frame, b_busy}, 3'b100);

      // Reset in the middle of C3, then 3C must go out clean.
      send(8'hC3, 1'b0, 1'b0);
      repeat (3) cycle();
      chk("c3_bit3_on_wire", {ser_frame, ser_data}, 2'b10);
      rst_n = 1'b0;
      cycle();
      rst_n = 1'b1;
      cycle();
      chk("ready_after_mid_reset", {in_ready, busy, ser_frame}, 3'b100);
      send(8'h3C, 1'b0, 1'b0);
      wait_ready(n);
      chk("3c_ready_delay", n, FRAME + 1);
      repeat (6) cycle();
      chk("no_remnant_frame", exp_q.size() + int'(active), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, checks);
      $fatal(1, "watchdog");
   end

endmodule
